cdc_flag_sender: RTL and testbench

Source-side companion to the flag/data domain crossing. It sits entirely in the fast (source) clock domain and buffers outgoing words in a small FIFO. It emits each word as a one-cycle `flag_o` pulse with `data_o` held stable, then enforces a programmable quiet gap so the slower destination domain can capture every pulse. Optionally, it waits for an acknowledge pulse returned through a reverse crossing, with a timeout, before the next word goes out.

---
 rtl/cdc_pkg.sv | 11 +
 rtl/sync_fifo.sv | 45 ++++
 rtl/cdc_flag_sender.sv | 98 +++++++++
 tb/tb_cdc_flag_sender.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared definitions for the flag/data crossing: sender FSM states and default word width.
package cdc_pkg;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2,
    GAP      = 2'd3
  } senderStateT;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; head is the word the next pop removes.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             pushData,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [WIDTH-1:0]             head
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr, rdPtr;
  logic             doPush, doPop;

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign full   = (level == LW'(DEPTH));
  assign empty  = (level == '0);
  assign head   = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      level <= level + LW'(doPush) - LW'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end
endmodule

// File: rtl/cdc_flag_sender.sv
// Source-side flag sender: queues words, emits one-cycle flag pulses with held data,
// optionally waits for a returned ack (with timeout), then enforces a quiet gap.
module cdc_flag_sender
  import cdc_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int DEPTH       = 4,
  parameter int GAP         = 8,
  parameter int ACK_EN      = 1,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       flag_o,
  output logic [WIDTH-1:0]           data_o,
  input  logic                       ack_i,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int GW = $clog2(GAP+1);
  localparam int TW = $clog2(ACK_TIMEOUT+1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TIMEOUT - 1);

  senderStateT      state, nextState;
  logic [GW-1:0]    gapCnt;
  logic [TW-1:0]    toCnt;
  logic             pop, toExpire;
  logic             fifoFull, fifoEmpty;
  logic [WIDTH-1:0] fifoHead;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) uFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_valid),
    .pushData (in_data),
    .pop      (pop),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .level    (level),
    .head     (fifoHead)
  );

  assign in_ready = ~fifoFull;
  assign busy     = (state != IDLE) | ~fifoEmpty;

  always_comb begin
    nextState = state;
    pop       = 1'b0;
    toExpire  = 1'b0;
    case (state)
      IDLE:     if (!fifoEmpty) nextState = SEND;
      SEND: begin
        pop       = 1'b1;
        nextState = (ACK_EN != 0) ? WAIT_ACK : cdc_pkg::GAP;
      end
      // An ack arriving in the expiry cycle takes priority over the timeout.
      WAIT_ACK: begin
        if (ack_i) begin
          nextState = cdc_pkg::GAP;
        end else if (toCnt == TO_LAST) begin
          nextState = cdc_pkg::GAP;
          toExpire  = 1'b1;
        end
      end
      cdc_pkg::GAP: if (gapCnt == GAP_LAST) nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gapCnt      <= '0;
      toCnt       <= '0;
      flag_o      <= 1'b0;
      data_o      <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= nextState;
      flag_o      <= (nextState == SEND);
      timeout_err <= toExpire;
      // data_o is loaded only on SEND entry so it stays stable for the slow side.
      if (nextState == SEND) data_o <= fifoHead;
      if (nextState != state) begin
        gapCnt <= '0;
        toCnt  <= '0;
      end else begin
        if (state == cdc_pkg::GAP) gapCnt <= gapCnt + GW'(1);
        if (state == WAIT_ACK)     toCnt  <= toCnt + TW'(1);
      end
    end
  end
endmodule

// File: tb/tb_cdc_flag_sender.sv
// Directed bench: instance A without ack phase, instance B with ack phase and short timeout.
module tb_cdc_flag_sender;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic       rstA, inValidA, inReadyA, flagA, ackA, busyA, toA;
  logic [7:0] inDataA, dataA;
  logic [2:0] levelA;
  logic       rstB, inValidB, inReadyB, flagB, ackB, busyB, toB;
  logic [7:0] inDataB, dataB;
  logic [2:0] levelB;

  cdc_flag_sender #(.WIDTH(8), .DEPTH(4), .GAP(8), .ACK_EN(0), .ACK_TIMEOUT(16)) dutA (
    .clk(clk), .rst(rstA), .in_valid(inValidA), .in_data(inDataA), .in_ready(inReadyA),
    .flag_o(flagA), .data_o(dataA), .ack_i(ackA), .busy(busyA), .timeout_err(toA),
    .level(levelA));

  cdc_flag_sender #(.WIDTH(8), .DEPTH(4), .GAP(8), .ACK_EN(1), .ACK_TIMEOUT(16)) dutB (
    .clk(clk), .rst(rstB), .in_valid(inValidB), .in_data(inDataB), .in_ready(inReadyB),
    .flag_o(flagB), .data_o(dataB), .ack_i(ackB), .busy(busyB), .timeout_err(toB),
    .level(levelB));

  logic [7:0] qA[$];
  logic [7:0] qB[$];
  int fA[$];
  int flagCntA = 0, flagCntB = 0, toCntA = 0, toCntB = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickN(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pushA(input logic [7:0] d, output int waited);
    bit acc = 1'b0;
    waited = 0;
    inValidA = 1'b1;
    inDataA = d;
    for (int t = 0; t < 64 && !acc; t++) begin
      acc = inReadyA;
      if (acc) qA.push_back(d);
      else waited++;
      tick();
    end
    chk("A push accepted", acc, 1);
    inValidA = 1'b0;
  endtask

  task automatic pushB(input logic [7:0] d);
    bit acc = 1'b0;
    inValidB = 1'b1;
    inDataB = d;
    for (int t = 0; t < 64 && !acc; t++) begin
      acc = inReadyB;
      if (acc) qB.push_back(d);
      tick();
    end
    chk("B push accepted", acc, 1);
    inValidB = 1'b0;
  endtask

  task automatic waitFlagB(output int t);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (flagB) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk("B flag arrived", seen, 1);
    t = cyc;
  endtask

  // Scoreboard monitors: every flag pops the oldest expected word.
  initial forever begin
    @(negedge clk);
    if (flagA) begin
      flagCntA++;
      fA.push_back(cyc);
      chk("A scoreboard has word at flag", (qA.size() > 0), 1);
      if (qA.size() > 0) chk("A data_o at flag", dataA, qA.pop_front());
    end
    if (toA) toCntA++;
    if (flagB) begin
      flagCntB++;
      chk("B scoreboard has word at flag", (qB.size() > 0), 1);
      if (qB.size() > 0) chk("B data_o at flag", dataB, qB.pop_front());
    end
    if (toB) toCntB++;
  end

  initial begin
    int w, L, c0, f, g, h, s, t;
    bit ok;
    rstA = 1'b1; inValidA = 1'b0; inDataA = '0; ackA = 1'b0;
    rstB = 1'b1; inValidB = 1'b0; inDataB = '0; ackB = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstA = 1'b0;
    rstB = 1'b0;
    chk("reset flagA", flagA, 0);
    chk("reset dataA", dataA, 0);
    chk("reset inReadyA", inReadyA, 1);
    chk("reset busyA", busyA, 0);
    chk("reset levelA", levelA, 0);
    chk("reset flagB", flagB, 0);
    chk("reset timeoutB", toB, 0);
    chk("reset busyB", busyB, 0);
    tick();

    // Single word: accepted in cycle n, flag in n+2.
    pushA(8'd66, w);
    chk("single n+1 level", levelA, 1);
    chk("single n+1 flag", flagA, 0);
    tick();
    chk("single n+2 flag", flagA, 1);
    chk("single n+2 data", dataA, 66);
    tick();
    chk("single n+3 flag", flagA, 0);
    chk("single n+3 data held", dataA, 66);
    chk("single n+3 busy", busyA, 1);
    chk("single n+3 level", levelA, 0);

    // Burst while in GAP: FIFO fills, fifth word stalls until the first pop.
    pushA(8'd66, w);
    pushA(8'd120, w);
    pushA(8'd1, w);
    pushA(8'd2, w);
    chk("burst level full", levelA, 4);
    chk("burst inReady full", inReadyA, 0);
    pushA(8'd3, w);
    chk("burst 5th push stall cycles", w, 6);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (flagCntA >= 6) begin ok = 1'b1; break; end
      tick();
    end
    chk("burst all flags seen", ok, 1);
    for (int i = 1; i < 6; i++) chk("burst pulse period", fA[i] - fA[i-1], 10);
    L = fA[5];
    tickN(L + 8 - cyc);
    chk("busy in last gap cycle", busyA, 1);
    tick();
    chk("busy falls after gap", busyA, 0);

    // Reset during GAP with three words queued.
    pushA(8'd11, w);
    pushA(8'd22, w);
    pushA(8'd33, w);
    pushA(8'd44, w);
    chk("pre-reset level", levelA, 3);
    tickN(2);
    rstA = 1'b1;
    tick();
    rstA = 1'b0;
    qA.delete();
    chk("mid reset flag", flagA, 0);
    chk("mid reset data", dataA, 0);
    chk("mid reset level", levelA, 0);
    chk("mid reset inReady", inReadyA, 1);
    chk("mid reset busy", busyA, 0);
    chk("mid reset timeout", toA, 0);
    c0 = flagCntA;
    tickN(30);
    chk("no flags after reset", flagCntA - c0, 0);
    chk("A never times out", toCntA, 0);

    // Ack path: ack in the 3rd WAIT_ACK cycle.
    pushB(8'd120);
    waitFlagB(f);
    pushB(8'd66);
    pushB(8'd9);
    tick();
    ackB = 1'b1;
    tick();
    ackB = 1'b0;
    waitFlagB(g);
    chk("ack period k=3", g - f, 13);
    chk("no timeout after ack", toCntB, 0);

    // Timeout: no ack for word 66.
    tickN(10);
    chk("data held in WAIT_ACK", dataB, 66);
    tickN(6);
    chk("timeout g+16", toB, 0);
    tick();
    chk("timeout g+17", toB, 1);
    tick();
    chk("timeout g+18", toB, 0);
    waitFlagB(h);
    chk("period after timeout", h - g, 26);

    // Ack coincides with expiry: ack wins.
    tickN(16);
    ackB = 1'b1;
    tick();
    ackB = 1'b0;
    chk("collision h+17", toB, 0);
    tick();
    chk("collision h+18", toB, 0);
    chk("timeout count after collision", toCntB, 1);

    // Stray acks during SEND and GAP are ignored.
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!busyB) begin ok = 1'b1; break; end
      tick();
    end
    chk("B idle before stray test", ok, 1);
    pushB(8'd5);
    pushB(8'd6);
    waitFlagB(s);
    ackB = 1'b1;
    tick();
    ackB = 1'b0;
    tickN(16);
    chk("stray SEND ack ignored", toB, 1);
    tickN(3);
    ackB = 1'b1;
    tick();
    ackB = 1'b0;
    waitFlagB(t);
    chk("stray GAP ack period", t - s, 26);
    tickN(17);
    chk("timeout after stray gap ack", toB, 1);
    tick();
    chk("total B timeouts", toCntB, 3);
    chk("B scoreboard drained", qB.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
